inst_ram_banked: RTL

//   Parametrised byte-banked instruction memory: one fetch port, one loader port, one clock.
//   NB = DATA_W/8 byte-lane banks with per-bank row addressing, so any byte-offset fetch
//   (RV32C half-word aligned included) completes in a single access.

---
 rtl/inst_ram_banked_pkg.sv | 29 ++
 rtl/inst_ram_banked_if.sv | 48 ++++
 rtl/inst_ram_banked_bank.sv | 38 +++
 rtl/inst_ram_banked.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/inst_ram_banked_pkg.sv
// -----------------------------------------------------------------------------
// inst_ram_banked_pkg
//   Shared definitions for the byte-banked instruction memory: controller state
//   encoding, the RV32I NOP word used to fill memory after reset, and a helper
//   that returns the NOP byte belonging to a given byte lane.
// -----------------------------------------------------------------------------
package inst_ram_banked_pkg;

  // CLEAR: post-reset NOP fill sweep in progress; RUN: normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Byte of the NOP word stored in byte lane 'lane'. Lanes beyond the 32-bit
  // word (wide configurations) are filled with zero.
  function automatic logic [7:0] nop_byte(input int lane);
    logic [31:0] shifted;
    shifted = '0;
    if (lane >= 0 && lane < 4) begin
      shifted = NOP_WORD >> (8 * lane);
    end
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/inst_ram_banked_if.sv
// -----------------------------------------------------------------------------
// inst_ram_banked_if
//   Bundles the fetch port and the loader port of the instruction memory.
//   slave  : the memory side (inst_ram_banked)
//   master : the fetch stage / program loader side
//   Signals:
//     fetch_req, fetch_addr, fetch_ack           master -> slave
//     fetch_ready, fetch_valid, fetch_data,
//     fetch_err                                  slave -> master
//     load_we, load_addr, load_data, load_be     master -> slave
//     load_ready, init_done                      slave -> master
// -----------------------------------------------------------------------------
interface inst_ram_banked_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              fetch_ack;

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [NB-1:0]     load_be;
  logic              load_ready;
  logic              init_done;

  modport slave (
    input  fetch_req, fetch_addr, fetch_ack,
    input  load_we, load_addr, load_data, load_be,
    output fetch_ready, fetch_valid, fetch_data, fetch_err,
    output load_ready, init_done
  );

  modport master (
    output fetch_req, fetch_addr, fetch_ack,
    output load_we, load_addr, load_data, load_be,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err,
    input  load_ready, init_done
  );

endinterface

// File: rtl/inst_ram_banked_bank.sv
// -----------------------------------------------------------------------------
// inst_ram_bank
//   One byte lane of the instruction memory: 8 bits x 2**ROW_W rows,
//   synchronous write and registered synchronous read.
//   Ports:
//     clk    clock
//     en     access enable
//     we     write enable (qualified by en)
//     addr   row address
//     wdata  write byte
//     rdata  read byte, valid the cycle after a read access
//   A write does not disturb rdata, so a word being held on the fetch output
//   stays stable while the loader writes elsewhere.
// -----------------------------------------------------------------------------
module inst_ram_bank #(
  parameter int ROW_W = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [ROW_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [0:(1<<ROW_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/inst_ram_banked.sv
// -----------------------------------------------------------------------------
// inst_ram_banked
//   Byte-banked instruction memory with one fetch port and one loader port.
//   NB = DATA_W/8 byte-lane banks, each with its own row address, so a fetch at
//   any byte offset is served by a single access. After reset the whole memory
//   is optionally swept with NOP rows before the ports open.
//   Ports:
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    inst_ram_banked_if.slave (fetch and loader handshakes, init_done)
//   NB must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module inst_ram_banked
  import inst_ram_banked_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_ram_banked_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int ROW_W = ADDR_W - OFF_W;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;
  localparam state_t RESET_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

  state_t           state_reg, state_next;
  logic [ROW_W-1:0] clear_row_reg, clear_row_next;
  logic             fetch_valid_reg, fetch_valid_next;
  logic             fetch_err_reg, fetch_err_next;
  logic [OFF_W-1:0] fetch_off_reg, fetch_off_next;

  logic             in_clear;
  logic             load_wr;
  logic             fetch_ready;
  logic             accept;
  logic [OFF_W-1:0] req_off;
  logic [ROW_W-1:0] req_row;
  logic [ROW_W-1:0] load_row;
  logic             load_lsb_unused;

  logic [NB-1:0][7:0] bank_rdata;
  logic [NB-1:0][7:0] rot_data;

  // ---------------------------------------------------------------------------
  // Controller FSM: sweep rows with NOPs, then run until the next reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET_STATE;
      clear_row_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_row_reg <= clear_row_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_row_next = clear_row_reg;
    case (state_reg)
      ST_CLEAR: begin
        clear_row_next = clear_row_reg + 1'b1;
        if (clear_row_reg == LAST_ROW) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  assign in_clear = (state_reg == ST_CLEAR);
  assign load_wr  = (state_reg == ST_RUN) && bus.load_we;

  // The loader wins a same-cycle collision; a held output blocks new fetches
  // until the consumer acknowledges it.
  assign fetch_ready = (state_reg == ST_RUN) && !bus.load_we &&
                       (!fetch_valid_reg || bus.fetch_ack);
  assign accept      = bus.fetch_req && fetch_ready;

  assign req_off  = bus.fetch_addr[OFF_W-1:0];
  assign req_row  = bus.fetch_addr[ADDR_W-1:OFF_W];
  assign load_row = bus.load_addr[ADDR_W-1:OFF_W];
  // Loads are word-aligned; the byte-offset bits carry no information.
  assign load_lsb_unused = ^bus.load_addr[OFF_W-1:0];

  // ---------------------------------------------------------------------------
  // Fetch output register: valid flag, wrap error and the offset needed to
  // rotate the bank outputs into address order.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_valid_next = fetch_valid_reg;
    fetch_err_next   = fetch_err_reg;
    fetch_off_next   = fetch_off_reg;
    if (accept) begin
      fetch_valid_next = 1'b1;
      fetch_err_next   = (req_off != '0) && (req_row == LAST_ROW);
      fetch_off_next   = req_off;
    end else if (bus.fetch_ack) begin
      fetch_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
      fetch_off_reg   <= '0;
    end else begin
      fetch_valid_reg <= fetch_valid_next;
      fetch_err_reg   <= fetch_err_next;
      fetch_off_reg   <= fetch_off_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Banks. Lanes below the fetch offset belong to the following row, which
  // wraps to row 0 at the top of memory.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);

    logic             bank_en;
    logic             bank_we;
    logic [ROW_W-1:0] fetch_row;
    logic [ROW_W-1:0] bank_addr;
    logic [7:0]       bank_wdata;

    assign fetch_row  = (LANE >= req_off) ? req_row : req_row + 1'b1;
    assign bank_we    = in_clear || (load_wr && bus.load_be[gi]);
    assign bank_en    = bank_we || accept;
    assign bank_addr  = in_clear ? clear_row_reg : (load_wr ? load_row : fetch_row);
    assign bank_wdata = in_clear ? nop_byte(gi) : bus.load_data[8*gi +: 8];

    inst_ram_bank #(
      .ROW_W (ROW_W)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (bank_we),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[gi])
    );
  end

  // Output byte k comes from lane (offset + k) mod NB, putting the byte at the
  // fetch address into the least significant position.
  for (genvar gi = 0; gi < NB; gi++) begin : g_rot
    logic [OFF_W-1:0] lane;
    assign lane         = fetch_off_reg + OFF_W'(gi);
    assign rot_data[gi] = bank_rdata[lane];
  end

  // Bank outputs are not reset, so the data bus is forced to zero whenever
  // nothing valid is being presented.
  assign bus.fetch_data  = fetch_valid_reg ? rot_data : '0;
  assign bus.fetch_valid = fetch_valid_reg;
  assign bus.fetch_err   = fetch_err_reg;
  assign bus.fetch_ready = fetch_ready;
  assign bus.load_ready  = (state_reg == ST_RUN);
  assign bus.init_done   = (state_reg == ST_RUN);

endmodule
